octavo_io_port_endpoint: RTL and testbench

//   External-side endpoint for one Octavo I/O port pair (read port + write port).

---
 rtl/octavo_io_port_endpoint.sv | 158 +++++++++++++++
 tb/tb_octavo_io_port_endpoint.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octavo_io_port_endpoint.sv
// External-side endpoint for one Octavo I/O port pair: an inbound FIFO feeding
// the core's read port and an outbound FIFO draining the core's write port.

module octavo_io_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic [AW:0]      count_next_c
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr_next;
    logic [AW-1:0]    rd_ptr_next;
    logic [WIDTH-1:0] head_next;

    // Next-state pointers/count; the head register is loaded with the entry
    // that will sit at rd_ptr after this edge, so show-ahead data is a flop.
    always_comb begin
        wr_ptr_next  = wr_ptr + AW'(push);
        rd_ptr_next  = rd_ptr + AW'(pop);
        count_next_c = count + (AW+1)'(push) - (AW+1)'(pop);
        head_next    = mem[rd_ptr_next];
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head      <= '0;
            not_empty <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next_c;
            head      <= head_next;
            not_empty <= (count_next_c != '0);
        end
    end

    // Storage array carries no reset; only the head register is observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

module octavo_io_port_endpoint #(
    parameter int unsigned WORD_WIDTH  = 36,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DEPTH_WIDTH = 2,
    parameter int unsigned WR_SLACK    = 0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_data,
    output logic                   io_read_EF,
    output logic [WORD_WIDTH-1:0]  io_read_data,
    input  logic                   io_rden,
    output logic                   io_write_EF,
    input  logic [WORD_WIDTH-1:0]  io_write_data,
    input  logic                   io_wren,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic [DEPTH_WIDTH:0]   in_count,
    output logic [DEPTH_WIDTH:0]   out_count,
    output logic                   rd_underflow,
    output logic                   wr_overflow
);

    localparam int unsigned      CW         = DEPTH_WIDTH + 1;
    localparam logic [CW-1:0]    FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0]    EF_LEVEL   = CW'(DEPTH - WR_SLACK);

    logic          in_push_c;
    logic          in_pop_c;
    logic          out_push_c;
    logic          out_pop_c;
    logic          out_full_c;
    logic [CW-1:0] in_count_next;
    logic [CW-1:0] out_count_next;

    // Handshake qualification; all terms come from registered state or inputs.
    always_comb begin
        in_push_c  = in_valid & in_ready;
        in_pop_c   = io_rden & io_read_EF;
        out_full_c = (out_count == FULL_LEVEL);
        out_push_c = io_wren & ~out_full_c;
        out_pop_c  = out_valid & out_ready;
    end

    octavo_io_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH),
        .AW    (DEPTH_WIDTH)
    ) u_in_fifo (
        .clk          (clock),
        .rst_n        (reset_n),
        .push         (in_push_c),
        .pop          (in_pop_c),
        .wdata        (in_data),
        .count        (in_count),
        .head         (io_read_data),
        .not_empty    (io_read_EF),
        .count_next_c (in_count_next)
    );

    octavo_io_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH),
        .AW    (DEPTH_WIDTH)
    ) u_out_fifo (
        .clk          (clock),
        .rst_n        (reset_n),
        .push         (out_push_c),
        .pop          (out_pop_c),
        .wdata        (io_write_data),
        .count        (out_count),
        .head         (out_data),
        .not_empty    (out_valid),
        .count_next_c (out_count_next)
    );

    // Ready/EF flags are precomputed from next counts; sticky error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready     <= 1'b0;
            io_write_EF  <= 1'b0;
            rd_underflow <= 1'b0;
            wr_overflow  <= 1'b0;
        end else begin
            in_ready     <= (in_count_next != FULL_LEVEL);
            io_write_EF  <= (out_count_next >= EF_LEVEL);
            rd_underflow <= rd_underflow | (io_rden & ~io_read_EF);
            wr_overflow  <= wr_overflow | (io_wren & out_full_c);
        end
    end

endmodule

// File: tb/tb_octavo_io_port_endpoint.sv
// Bench for octavo_io_port_endpoint: directed table, corner sequences and
// randomized traffic against a queue-based reference model.

module tb_octavo_io_port_endpoint;

    localparam int unsigned W     = 36;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 2;
    localparam int unsigned SLACK = 1;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          io_read_EF;
    logic [W-1:0]  io_read_data;
    logic          io_rden;
    logic          io_write_EF;
    logic [W-1:0]  io_write_data;
    logic          io_wren;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [DW:0]   in_count;
    logic [DW:0]   out_count;
    logic          rd_underflow;
    logic          wr_overflow;

    int tests;
    int fails;

    octavo_io_port_endpoint #(
        .WORD_WIDTH  (W),
        .DEPTH       (DEPTH),
        .DEPTH_WIDTH (DW),
        .WR_SLACK    (SLACK)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .io_read_EF    (io_read_EF),
        .io_read_data  (io_read_data),
        .io_rden       (io_rden),
        .io_write_EF   (io_write_EF),
        .io_write_data (io_write_data),
        .io_wren       (io_wren),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .in_count      (in_count),
        .out_count     (out_count),
        .rd_underflow  (rd_underflow),
        .wr_overflow   (wr_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: plain queues plus flags.
    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    bit           m_in_ready;
    bit           m_uf;
    bit           m_of;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        in_q.delete();
        out_q.delete();
        m_in_ready = 1'b0;
        m_uf = 1'b0;
        m_of = 1'b0;
    endtask

    task automatic model_edge();
        bit in_push, in_pop, out_full, out_push, out_pop;
        in_push  = in_valid && m_in_ready;
        in_pop   = io_rden && (in_q.size() != 0);
        if (io_rden && (in_q.size() == 0)) m_uf = 1'b1;
        if (in_pop) void'(in_q.pop_front());
        if (in_push) in_q.push_back(in_data);
        m_in_ready = (in_q.size() != DEPTH);

        out_full = (out_q.size() == DEPTH);
        if (io_wren && out_full) m_of = 1'b1;
        out_pop  = out_ready && (out_q.size() != 0);
        out_push = io_wren && !out_full;
        if (out_pop) void'(out_q.pop_front());
        if (out_push) out_q.push_back(io_write_data);
    endtask

    task automatic check_all();
        chk("in_ready", 64'(in_ready), 64'(m_in_ready));
        chk("io_read_EF", 64'(io_read_EF), 64'(in_q.size() != 0));
        chk("in_count", 64'(in_count), 64'(in_q.size()));
        if (in_q.size() != 0) chk("io_read_data", 64'(io_read_data), 64'(in_q[0]));
        chk("out_valid", 64'(out_valid), 64'(out_q.size() != 0));
        chk("out_count", 64'(out_count), 64'(out_q.size()));
        if (out_q.size() != 0) chk("out_data", 64'(out_data), 64'(out_q[0]));
        chk("io_write_EF", 64'(io_write_EF), 64'(out_q.size() >= (DEPTH - SLACK)));
        chk("rd_underflow", 64'(rd_underflow), 64'(m_uf));
        chk("wr_overflow", 64'(wr_overflow), 64'(m_of));
    endtask

    // Check current state at negedge, then advance one edge.
    task automatic tick();
        @(negedge clock);
        check_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; io_rden = 1'b0;
        io_wren = 1'b0; io_write_data = '0; out_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_inputs();
        model_clear();
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_in_count", 64'(in_count), 64'd0);
        chk("rst_io_read_data", 64'(io_read_data), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         rd;
        logic         we;
        logic [W-1:0] wd;
        logic         ordy;
        logic [DW:0]  e_ic;
        logic [DW:0]  e_oc;
        logic         e_ref;
        logic         e_wef;
        logic         e_uf;
        logic         e_of;
        logic [W-1:0] e_rh;
        logic [W-1:0] e_oh;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        idle_inputs();
        model_clear();

        //            iv id    rd we wd     or  ic oc ref wef uf of rh     oh
        tbl[0]  = '{1, 'h11, 0, 0, 'h0,  0,  1, 0, 1, 0, 0, 0, 'h11, 'h0};
        tbl[1]  = '{1, 'h22, 0, 0, 'h0,  0,  2, 0, 1, 0, 0, 0, 'h11, 'h0};
        tbl[2]  = '{0, 'h0,  1, 0, 'h0,  0,  1, 0, 1, 0, 0, 0, 'h22, 'h0};
        tbl[3]  = '{0, 'h0,  1, 0, 'h0,  0,  0, 0, 0, 0, 0, 0, 'h0,  'h0};
        tbl[4]  = '{0, 'h0,  1, 0, 'h0,  0,  0, 0, 0, 0, 1, 0, 'h0,  'h0};
        tbl[5]  = '{0, 'h0,  0, 1, 'hA0, 0,  0, 1, 0, 0, 1, 0, 'h0,  'hA0};
        tbl[6]  = '{0, 'h0,  0, 1, 'hA1, 0,  0, 2, 0, 0, 1, 0, 'h0,  'hA0};
        tbl[7]  = '{0, 'h0,  0, 1, 'hA2, 0,  0, 3, 0, 1, 1, 0, 'h0,  'hA0};
        tbl[8]  = '{0, 'h0,  0, 1, 'hA3, 0,  0, 4, 0, 1, 1, 0, 'h0,  'hA0};
        tbl[9]  = '{0, 'h0,  0, 1, 'hA4, 0,  0, 4, 0, 1, 1, 1, 'h0,  'hA0};
        tbl[10] = '{0, 'h0,  0, 0, 'h0,  1,  0, 3, 0, 1, 1, 1, 'h0,  'hA1};
        tbl[11] = '{0, 'h0,  0, 0, 'h0,  1,  0, 2, 0, 0, 1, 1, 'h0,  'hA2};
        tbl[12] = '{0, 'h0,  0, 0, 'h0,  1,  0, 1, 0, 0, 1, 1, 'h0,  'hA3};
        tbl[13] = '{0, 'h0,  0, 0, 'h0,  1,  0, 0, 0, 0, 1, 1, 'h0,  'h0};
        tbl[14] = '{1, 'h33, 0, 0, 'h0,  0,  1, 0, 1, 0, 1, 1, 'h33, 'h0};
        tbl[15] = '{1, 'h44, 0, 0, 'h0,  0,  2, 0, 1, 0, 1, 1, 'h33, 'h0};
        tbl[16] = '{1, 'h55, 1, 0, 'h0,  0,  2, 0, 1, 0, 1, 1, 'h44, 'h0};
        tbl[17] = '{0, 'h0,  1, 0, 'h0,  0,  1, 0, 1, 0, 1, 1, 'h55, 'h0};
        tbl[18] = '{0, 'h0,  1, 0, 'h0,  0,  0, 0, 0, 0, 1, 1, 'h0,  'h0};

        // Directed table: read path, underflow, slack/overflow, drain, push+pop.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id; io_rden = tbl[i].rd;
            io_wren = tbl[i].we; io_write_data = tbl[i].wd; out_ready = tbl[i].ordy;
            tick();
            chk($sformatf("t%0d_in_count", i), 64'(in_count), 64'(tbl[i].e_ic));
            chk($sformatf("t%0d_out_count", i), 64'(out_count), 64'(tbl[i].e_oc));
            chk($sformatf("t%0d_io_read_EF", i), 64'(io_read_EF), 64'(tbl[i].e_ref));
            chk($sformatf("t%0d_io_write_EF", i), 64'(io_write_EF), 64'(tbl[i].e_wef));
            chk($sformatf("t%0d_rd_underflow", i), 64'(rd_underflow), 64'(tbl[i].e_uf));
            chk($sformatf("t%0d_wr_overflow", i), 64'(wr_overflow), 64'(tbl[i].e_of));
            if (tbl[i].e_ref) chk($sformatf("t%0d_io_read_data", i), 64'(io_read_data), 64'(tbl[i].e_rh));
            if (tbl[i].e_oc != 0) chk($sformatf("t%0d_out_data", i), 64'(out_data), 64'(tbl[i].e_oh));
        end
        idle_inputs();
        tick();

        // Inbound full: fifth word held until one pop frees a slot.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = W'(32'h60 + i);
            tick();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_in_count", 64'(in_count), 64'd4);
        in_data = W'(32'h99);
        tick();
        tick();
        chk("held_in_count", 64'(in_count), 64'd4);
        chk("held_head", 64'(io_read_data), 64'h60);
        io_rden = 1'b1;
        tick();
        chk("pop_in_count", 64'(in_count), 64'd3);
        chk("pop_in_ready", 64'(in_ready), 64'd1);
        io_rden = 1'b0;
        tick();
        chk("refill_in_count", 64'(in_count), 64'd4);
        chk("refill_in_ready", 64'(in_ready), 64'd0);
        chk("refill_head", 64'(io_read_data), 64'h61);
        idle_inputs();
        tick();

        // Asynchronous reset mid-stream with both FIFOs at 3 and a flag set.
        do_reset();
        io_rden = 1'b1;
        tick();
        io_rden = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = W'(32'h70 + i);
            io_wren = 1'b1; io_write_data = W'(32'h80 + i);
            tick();
        end
        idle_inputs();
        chk("pre_in_count", 64'(in_count), 64'd3);
        chk("pre_out_count", 64'(out_count), 64'd3);
        chk("pre_rd_underflow", 64'(rd_underflow), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_in_count", 64'(in_count), 64'd0);
        chk("arst_out_count", 64'(out_count), 64'd0);
        chk("arst_io_read_EF", 64'(io_read_EF), 64'd0);
        chk("arst_io_write_EF", 64'(io_write_EF), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_rd_underflow", 64'(rd_underflow), 64'd0);
        chk("arst_wr_overflow", 64'(wr_overflow), 64'd0);
        do_reset();

        // Randomized traffic with alternating fill/drain bias.
        for (int c = 0; c < 3000; c++) begin
            int p;
            p = ((c / 200) % 2 == 0) ? 70 : 30;
            in_valid      = ($urandom_range(0, 99) < p);
            in_data       = W'({$urandom, $urandom});
            io_rden       = ($urandom_range(0, 99) < (100 - p));
            io_wren       = ($urandom_range(0, 99) < p);
            io_write_data = W'({$urandom, $urandom});
            out_ready     = ($urandom_range(0, 99) < (100 - p));
            tick();
        end
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
